// File: rtl/mem_dump_reader.sv
// Debug readback engine for the shared risc_v data/instruction memory.
// After a run it sweeps a word-aligned address window through an async-read port.
// Each word goes out as {addr,data} over a valid/ready stream, and the engine
// keeps a running checksum of the words the sink accepts.
// The core is held frozen for the whole time the engine is not idle.
module mem_dump_reader #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_rdata,
  output logic             core_hold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_addr,
  output logic [DW-1:0]    out_data,
  output logic [DW-1:0]    checksum,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Next word address, words still to send, and the address last presented to memory
  logic [AW-1:0]    addr;
  logic [CNT_W-1:0] remaining;
  logic [AW-1:0]    mem_addr_q;

  // State register; a reset drops any dump in progress immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status decode; SEND leaves only on an accepted word, and the final word goes to FIN
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    core_hold  = (state != IDLE);
    mem_addr   = mem_addr_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (word_count == '0) ? FIN : READ;
        end
      end
      READ: begin
        mem_addr   = addr;
        state_next = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = (remaining == CNT_W'(1)) ? FIN : READ;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the window on start, capture the read word, and advance on each accepted transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      remaining  <= '0;
      mem_addr_q <= '0;
      out_addr   <= '0;
      out_data   <= '0;
      checksum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr & ~AW'(3);
            remaining <= word_count;
            checksum  <= '0;
          end
        end
        READ: begin
          mem_addr_q <= addr;
          out_addr   <= addr;
          out_data   <= mem_rdata;
        end
        SEND: begin
          if (out_ready) begin
            checksum  <= checksum + out_data;
            addr      <= addr + AW'(4);
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader.
// Directed and randomized dumps are checked against an expected word list.
// That list is built from the base address and word count alone.
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        core_hold;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [31:0] checksum;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] t2_vals [10] = '{32'd2, 32'd3, 32'd1, 32'd7, 32'd4, 32'd8, 32'd9, 32'd4, 32'd125, 32'd2};

  mem_dump_reader #(.AW(32), .DW(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .core_hold  (core_hold),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .checksum   (checksum),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Memory contents: the small array at 100..136, and a scrambled address pattern everywhere else
  function automatic logic [31:0] memfn(input logic [31:0] a);
    int idx;
    if (a >= 32'd100 && a <= 32'd136) begin
      idx = int'((a - 32'd100) >> 2);
      return t2_vals[idx];
    end
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Asynchronous memory read port
  always_comb mem_rdata = memfn(mem_addr);

  // Records one comparison and reports it if it does not match
  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Runs one dump and checks it against the expected word list.
  // mode 0: ready always high. mode 1: ready toggles every 3 cycles. mode 2: random ready.
  // inject: pulse start (base 0) mid-dump. abort_at > 0: reset once the stream is valid from that cycle on.
  task automatic applyStimulus(input logic [31:0] b, input logic [15:0] n, input int mode,
                               input bit inject, input int abort_at);
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_sum;
    logic [31:0] a;
    logic [31:0] held_a;
    logic [31:0] held_d;
    int idx;
    int cyc;
    int budget;
    int first_valid;
    bit prev_stall;
    bit finished;

    exp_sum = '0;
    a = b & 32'hFFFF_FFFC;
    for (int i = 0; i < (abort_at > 0 ? 64 : int'(n)); i++) begin
      exp_addr.push_back(a);
      exp_data.push_back(memfn(a));
      exp_sum = exp_sum + memfn(a);
      a = a + 32'd4;
    end

    @(negedge clk);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;

    idx = 0;
    cyc = 1;
    first_valid = -1;
    prev_stall = 1'b0;
    finished = 1'b0;
    held_a = '0;
    held_d = '0;
    budget = 10 * int'(n) + 40;
    if (budget > 2000) budget = 2000;

    while (cyc <= budget) begin
      start = (inject && cyc == 5);
      if (inject && cyc == 5) begin
        base_addr  = 32'd0;
        word_count = 16'd3;
      end

      if (done) begin
        checkOutput("checksum", 96'(checksum), 96'(exp_sum));
        checkOutput("word_total", 96'(idx), 96'(n));
        if (n == 16'd0) begin
          checkOutput("zero_done_latency", 96'(cyc), 96'd1);
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("post_done", 96'({done, busy, core_hold, out_valid}), 96'd0);
        checkOutput("checksum_hold", 96'(checksum), 96'(exp_sum));
        finished = 1'b1;
        break;
      end

      if (abort_at > 0 && cyc >= abort_at && out_valid) begin
        rst = 1'b1;
        #1;
        checkOutput("abort_flags", 96'({out_valid, busy, core_hold, done}), 96'd0);
        checkOutput("abort_checksum", 96'(checksum), 96'd0);
        checkOutput("abort_regs", 96'({out_addr, out_data, mem_addr}), 96'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_after_reset", 96'({out_valid, busy, done}), 96'd0);
        finished = 1'b1;
        break;
      end

      checkOutput("busy", 96'({busy, core_hold}), 96'b11);

      if (prev_stall) begin
        checkOutput("stall_hold", {out_valid, out_addr, out_data}, {1'b1, held_a, held_d});
      end

      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc / 3) % 2) == 0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase

      if (out_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          checkOutput("first_valid_latency", 96'(cyc), 96'd2);
        end
        if (out_ready) begin
          if (idx < exp_addr.size()) begin
            checkOutput("word_addr", 96'(out_addr), 96'(exp_addr[idx]));
            checkOutput("word_data", 96'(out_data), 96'(exp_data[idx]));
          end else begin
            checkOutput("extra_word", 96'(out_addr), 96'(32'hFFFF_FFFF) + 96'd1);
          end
          idx++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          held_a = out_addr;
          held_d = out_data;
        end
      end else begin
        prev_stall = 1'b0;
      end

      @(negedge clk);
      cyc++;
    end

    start = 1'b0;
    if (!finished) begin
      checkOutput("timeout", 96'd0, 96'd1);
    end
  endtask

  initial begin
    #2;
    $display("[TB] reset state");
    checkOutput("reset_flags", 96'({out_valid, busy, core_hold, done}), 96'd0);
    checkOutput("reset_regs", {mem_addr, out_addr, out_data}, 96'd0);
    checkOutput("reset_checksum", 96'(checksum), 96'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] array dump");
    applyStimulus(32'd100, 16'd10, 0, 1'b0, 0);
    $display("[TB] array dump with backpressure");
    applyStimulus(32'd100, 16'd10, 1, 1'b0, 0);
    $display("[TB] zero count and misaligned base");
    applyStimulus(32'd7, 16'd0, 0, 1'b0, 0);
    applyStimulus(32'd102, 16'd1, 0, 1'b0, 0);
    $display("[TB] address wrap");
    applyStimulus(32'hFFFF_FFFC, 16'd2, 0, 1'b0, 0);
    $display("[TB] start while busy");
    applyStimulus(32'd100, 16'd10, 0, 1'b1, 0);
    $display("[TB] reset mid-dump");
    applyStimulus(32'd100, 16'd10, 1, 1'b0, 12);
    $display("[TB] maximum count, aborted");
    applyStimulus($urandom, 16'hFFFF, 2, 1'b0, 60);

    $display("[TB] random dumps");
    for (int k = 0; k < 12; k++) begin
      applyStimulus($urandom, 16'($urandom_range(0, 20)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
